// File: rtl/traffic_ctrl_n.sv
// N-approach traffic-light controller: round-robin service, demand-extended green,
// emergency all-red override. Optional pedestrian walk phase under `PED_WALK_EN.
module traffic_ctrl_n #(
  parameter int NDIR      = 2,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 12,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int CNT_W     = 4,
`ifdef PED_WALK_EN
  parameter int WALK_T    = 6,
`endif
  parameter int IDX_W     = $clog2(NDIR)
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             TICK,
  input  logic [NDIR-1:0]  SENSE,
  input  logic             EMERG,
`ifdef PED_WALK_EN
  input  logic             PED_REQ,
  output logic             WALK,
`endif
  output logic [NDIR-1:0]  GREEN,
  output logic [NDIR-1:0]  YELLOW,
  output logic [NDIR-1:0]  RED,
  output logic [IDX_W-1:0] PHASE,
  output logic [2:0]       dbg_state_o
);

  localparam logic [2:0] S_ALLRED = 3'd0;
  localparam logic [2:0] S_GREEN  = 3'd1;
  localparam logic [2:0] S_YELLOW = 3'd2;
  localparam logic [2:0] S_EMRED  = 3'd3;
`ifdef PED_WALK_EN
  localparam logic [2:0] S_WALK   = 3'd4;
  localparam logic [CNT_W-1:0] WALK_LD = CNT_W'(WALK_T);
`endif

  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] GMIN_C    = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] GMAX_C    = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [IDX_W-1:0] phase_q, phase_d;

  logic [NDIR-1:0]  cur_oh;
  logic             sense_cur;
  logic             other_dem;
  logic [CNT_W-1:0] cnt_inc;
  logic             expired;
  logic [IDX_W-1:0] arb_phase;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

`ifdef PED_WALK_EN
  logic ped_q;
  logic pend_q, pend_d;
`endif

  assign cur_oh    = NDIR'(1) << phase_q;
  assign sense_cur = SENSE[phase_q];
  assign other_dem = |(SENSE & ~cur_oh);
  assign cnt_inc   = (timer_q >= GMAX_C) ? GMAX_C : timer_q + ONE_C;
  assign expired   = (timer_q <= ONE_C);

  // Round-robin: look at PHASE+1 first; the current approach is checked last.
  always_comb begin
    arb_phase = phase_q;
    cand_idx  = phase_q;
    found     = 1'b0;
    for (int i = 1; i <= NDIR; i++) begin
      cand_idx = IDX_W'((int'(phase_q) + i) % NDIR);
      if (!found && SENSE[cand_idx]) begin
        arb_phase = cand_idx;
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    phase_d = phase_q;
`ifdef PED_WALK_EN
    pend_d  = pend_q | (PED_REQ & ~ped_q);
`endif
    case (state_q)
      S_ALLRED: begin
        if (TICK) begin
          if (expired) begin
            if (EMERG) begin
              state_d = S_EMRED;
              timer_d = ALLRED_LD;
`ifdef PED_WALK_EN
            end else if (pend_q) begin
              state_d = S_WALK;
              timer_d = WALK_LD;
`endif
            end else begin
              state_d = S_GREEN;
              timer_d = '0;
              phase_d = arb_phase;
            end
          end else begin
            timer_d = timer_q - ONE_C;
          end
        end
      end
      S_GREEN: begin
        // Emergency ends green on the next edge, independent of TICK and GREEN_MIN.
        if (EMERG) begin
          state_d = S_YELLOW;
          timer_d = YELLOW_LD;
        end else if (TICK) begin
          timer_d = cnt_inc;
          if (cnt_inc >= GMIN_C && other_dem && (!sense_cur || cnt_inc == GMAX_C)) begin
            state_d = S_YELLOW;
            timer_d = YELLOW_LD;
          end
        end
      end
      S_YELLOW: begin
        if (TICK) begin
          if (expired) begin
            state_d = S_ALLRED;
            timer_d = ALLRED_LD;
          end else begin
            timer_d = timer_q - ONE_C;
          end
        end
      end
      S_EMRED: begin
        if (TICK && !EMERG) begin
          state_d = S_ALLRED;
          timer_d = ALLRED_LD;
        end
      end
`ifdef PED_WALK_EN
      S_WALK: begin
        // An emergency abort keeps the pending request so the walk is retried later.
        if (EMERG) begin
          state_d = S_ALLRED;
          timer_d = ALLRED_LD;
        end else if (TICK) begin
          if (expired) begin
            state_d = S_ALLRED;
            timer_d = ALLRED_LD;
            pend_d  = PED_REQ & ~ped_q;
          end else begin
            timer_d = timer_q - ONE_C;
          end
        end
      end
`endif
      default: begin
        state_d = S_ALLRED;
        timer_d = ALLRED_LD;
      end
    endcase
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= S_ALLRED;
      timer_q <= ALLRED_LD;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      phase_q <= phase_d;
    end
  end

`ifdef PED_WALK_EN
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      ped_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      ped_q  <= PED_REQ;
      pend_q <= pend_d;
    end
  end

  assign WALK = (state_q == S_WALK);
`endif

  always_comb begin
    GREEN  = '0;
    YELLOW = '0;
    RED    = '1;
    case (state_q)
      S_GREEN: begin
        GREEN = cur_oh;
        RED   = ~cur_oh;
      end
      S_YELLOW: begin
        YELLOW = cur_oh;
        RED    = ~cur_oh;
      end
      default: ;
    endcase
  end

  assign PHASE       = phase_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/traffic_ctrl_n.md
# traffic_ctrl_n

Parametrised N-approach traffic-light controller, the successor to the fixed two-approach benchmark controller in our ISCAS89 set. It serves one approach at a time with green, yellow and all-red phases, and uses demand-actuated green extension, round-robin arbitration and an emergency all-red override. All timing is counted in TICK strobes so the block runs from any CK rate, and it is used both as an SFQ benchmark circuit and as a reusable controller.

## Interface
- NDIR, 2: number of approaches, legal range 2..8
- GREEN_MIN, 4: minimum green, in ticks (≥1)
- GREEN_MAX, 12: maximum green when competing demand exists (≥GREEN_MIN)
- YELLOW_T, 3: yellow duration, in ticks (≥1)
- ALLRED_T, 1: all-red clearance, in ticks (≥1)
- CNT_W, 4: timer width; must satisfy 2^CNT_W > max of all tick parameters
- IDX_W, $clog2(NDIR): width of the PHASE output
- CK  in  1  clock; all state changes on the rising edge
- RST  in  1  reset; asynchronous, active-high
- TICK  in  1  timing strobe; timers advance only on cycles where TICK=1
- SENSE  in  NDIR  vehicle demand per approach, level-sensitive, sampled on CK
- EMERG  in  1  emergency override request, level-sensitive
- GREEN  out  NDIR  green lamp per approach
- YELLOW  out  NDIR  yellow lamp per approach
- RED  out  NDIR  red lamp per approach
- PHASE  out  IDX_W  index of the approach currently or last served

## Operation
- Lamp encoding: each approach's {RED, YELLOW, GREEN} is always one-hot. All non-served approaches show RED.
- Outputs are Moore: a combinational decode of the registered state and PHASE only.
- States and transitions:
  - ALLRED: every approach shows red. The timer loads ALLRED_T on entry.
    - At expiry, with EMERG=0: arbitrate, load PHASE, go to GREEN.
    - At expiry, with EMERG=1: go to EMRED.
  - GREEN: the timer counts up from 0 on each TICK and saturates at GREEN_MAX.
    - "other" means any SENSE bit except SENSE[PHASE].
    - Once count ≥ GREEN_MIN, go to YELLOW if other demand is present AND (SENSE[PHASE]=0 OR count=GREEN_MAX).
    - With no other demand, green rests on the current approach indefinitely.
  - YELLOW: lasts YELLOW_T ticks, then goes to ALLRED.
  - EMRED: every approach shows red while EMERG=1. When EMERG=0, go to ALLRED with a full ALLRED_T.
- Arbitration: search (PHASE+1) mod NDIR upward, wrapping, and select the first approach with SENSE=1. If no approach has demand, PHASE is unchanged.
- Emergency:
  - EMERG=1 during GREEN forces YELLOW on the next CK edge, regardless of TICK or GREEN_MIN.
  - EMERG=1 during YELLOW or ALLRED does not shorten either phase.
  - ALLRED exits to EMRED while EMERG=1.
- Simultaneous events: if EMERG rises on the same cycle as a GREEN→YELLOW decision, the result is a single YELLOW entry with a fresh YELLOW_T.
- Timer arithmetic: unsigned CNT_W-bit. The count never wraps; it saturates at the current phase limit.

## Timing
- Reset values:
  - state=ALLRED, timer=ALLRED_T, PHASE=0
  - RED=all 1s, GREEN=0, YELLOW=0
- RST asserted at any time, including mid-phase, forces the reset values immediately (asynchronously). The first evaluation happens at the first CK edge after RST falls.
- Phase length is exactly the parameter value in TICK-qualified edges. Outputs change in the cycle after the deciding edge; there is no additional pipeline latency.
- TICK=0: timers hold. Only the EMERG forcing into YELLOW can change state.
- TICK tied high: with NDIR=2 and default parameters, one full service cycle is 4 green + 3 yellow + 1 all-red = 8 cycles.

## Configuration
- PED_WALK_EN defined:
  - Adds input PED_REQ (1 bit), output WALK (1 bit) and parameter WALK_T (default 6).
  - A rising PED_REQ is latched into a pending flag.
  - The next ALLRED expiry with the flag set (and EMERG=0) enters a WALK state instead of arbitrating. In WALK, all approaches show red and WALK=1 for WALK_T ticks.
  - WALK then goes to ALLRED (full ALLRED_T), clears the flag, then arbitrates normally.
  - EMERG during WALK aborts it to ALLRED with WALK=0; the pending flag is kept.
  - WALK resets to 0 and the flag resets to clear.
- PED_WALK_EN undefined:
  - The ports, parameter and state are absent.
  - Behaviour is exactly as described above.

## Test plan
- Reset with TICK=1, SENSE=0: RED=2'b11 during reset; after 1 tick, GREEN=2'b01 with PHASE=0, held for 50 cycles with no change.
- SENSE=2'b10 from green on approach 0: GREEN[0] lasts 4 cycles, then YELLOW[0] for 3 cycles, RED=2'b11 for 1 cycle, then GREEN=2'b10 with PHASE=1.
- SENSE=2'b11 constant: each green lasts 12 cycles (GREEN_MAX), and service alternates PHASE 0,1,0.
- EMERG raised on green cycle 2 and held 10 cycles: YELLOW on the next cycle for 3 cycles, all red until EMERG falls, then 1 all-red cycle, then arbitration.
- TICK=0 for 100 cycles during YELLOW: outputs are frozen. When TICK resumes, the remaining yellow ticks complete exactly.
- RST pulsed mid-YELLOW on approach 1: RED=2'b11 and PHASE=0 in the same cycle, before the next CK edge.
